// File: rtl/pc_sequencer_if.sv
// ============================================================================
// Module   : pc_sequencer_if
// Brief    : Decode/ALU-to-PC-sequencer control and fetch-address bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pc_sequencer_if #(
    parameter int XLEN = 32
);
    logic              stall;
    logic              branch;
    logic              jump;
    logic              jalr_sel;
    logic [2:0]        funct3;
    logic              zero;
    logic              less_than;
    logic              less_than_u;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   alu_out;
    logic              fence;
    logic              mem_idle;
    logic              trap;
    logic [XLEN-1:0]   trap_vec;
    logic [XLEN-1:0]   pc_out;
    logic [XLEN-1:0]   next_pc;
    logic [XLEN-1:0]   predecessor;
    logic [XLEN-1:0]   successor;
    logic              fence_busy;
    logic              redirect;
    logic              misaligned;

    modport master (
        output stall, branch, jump, jalr_sel, funct3, zero, less_than,
               less_than_u, imm, alu_out, fence, mem_idle, trap, trap_vec,
        input  pc_out, next_pc, predecessor, successor, fence_busy,
               redirect, misaligned
    );

    modport slave (
        input  stall, branch, jump, jalr_sel, funct3, zero, less_than,
               less_than_u, imm, alu_out, fence, mem_idle, trap, trap_vec,
        output pc_out, next_pc, predecessor, successor, fence_busy,
               redirect, misaligned
    );
endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Brief    : RV32 PC register with branch/jump/trap redirect and fence drain.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_sequencer #(
    parameter int              XLEN        = 32,
    parameter int              PC_STEP     = 1,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              FENCE_DRAIN = 2,
    parameter int              ALIGN_BITS  = 0
) (
    input  wire              clk,
    input  wire              reset,
    pc_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRAIN  = 2'd1,
        S_RESUME = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] c_STEP       = XLEN'(PC_STEP);
    localparam logic [3:0]      c_DRAIN_INIT = 4'(FENCE_DRAIN - 1);

    state_t            r_state;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_pred;
    logic [XLEN-1:0]   r_succ;
    logic [3:0]        r_cnt;
    logic              r_busy;
    logic              r_mis;

    state_t            w_state_nxt;
    logic [XLEN-1:0]   w_pc_nxt;
    logic [XLEN-1:0]   w_pred_nxt;
    logic [XLEN-1:0]   w_succ_nxt;
    logic [3:0]        w_cnt_nxt;
    logic              w_mis_nxt;
    logic              w_redirect;
    logic              w_cond;
    logic              w_taken;
    logic              w_unaligned;
    logic              w_bad;
    logic [XLEN-1:0]   w_next_pc;
    logic [XLEN-1:0]   w_target;

    assign w_next_pc = r_pc + c_STEP;
    assign w_target  = (bus.jump && bus.jalr_sel) ? bus.alu_out : (r_pc + bus.imm);

    always_comb begin
        w_cond = 1'b0;
        case (bus.funct3)
            3'b000:  w_cond = bus.zero;
            3'b001:  w_cond = ~bus.zero;
            3'b100:  w_cond = bus.less_than;
            3'b101:  w_cond = ~bus.less_than;
            3'b110:  w_cond = bus.less_than_u;
            3'b111:  w_cond = ~bus.less_than_u;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_taken = bus.jump | (bus.branch & w_cond);

    generate
        if (ALIGN_BITS > 0) begin : g_align_chk
            assign w_unaligned = |w_target[ALIGN_BITS-1:0];
        end else begin : g_no_align
            assign w_unaligned = 1'b0;
        end
    endgenerate

    assign w_bad = w_taken & w_unaligned;

    // Trap overrides everything; otherwise a busy fence owns the PC.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pred_nxt  = r_pred;
        w_succ_nxt  = r_succ;
        w_cnt_nxt   = r_cnt;
        w_mis_nxt   = 1'b0;
        w_redirect  = 1'b0;
        if (bus.trap) begin
            w_pc_nxt    = bus.trap_vec;
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.stall) begin
                        w_pc_nxt = r_pc;
                    end else if (bus.fence) begin
                        w_state_nxt = S_DRAIN;
                        w_pred_nxt  = r_pc;
                        w_succ_nxt  = w_next_pc;
                        w_cnt_nxt   = c_DRAIN_INIT;
                    end else if (w_taken && !w_bad) begin
                        w_pc_nxt   = w_target;
                        w_redirect = 1'b1;
                    end else begin
                        w_pc_nxt  = w_next_pc;
                        w_mis_nxt = w_bad;
                    end
                end
                S_DRAIN: begin
                    if (r_cnt != 4'd0) begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                    if ((r_cnt == 4'd0) && bus.mem_idle) begin
                        w_state_nxt = S_RESUME;
                    end
                end
                S_RESUME: begin
                    w_pc_nxt    = r_succ;
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_pred  <= '0;
            r_succ  <= '0;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_mis   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_pred  <= w_pred_nxt;
            r_succ  <= w_succ_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_mis   <= w_mis_nxt;
        end
    end

    assign bus.pc_out      = r_pc;
    assign bus.next_pc     = w_next_pc;
    assign bus.predecessor = r_pred;
    assign bus.successor   = r_succ;
    assign bus.fence_busy  = r_busy;
    assign bus.redirect    = w_redirect;
    assign bus.misaligned  = r_mis;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Directed scoreboard bench for pc_sequencer (default + aligned cfg).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb[$];

    pc_sequencer_if #(.XLEN(32)) p_if ();
    pc_sequencer_if #(.XLEN(32)) q_if ();

    pc_sequencer #(
        .XLEN(32), .PC_STEP(1), .RESET_PC(32'h0), .FENCE_DRAIN(2), .ALIGN_BITS(0)
    ) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (p_if)
    );

    pc_sequencer #(
        .XLEN(32), .PC_STEP(4), .RESET_PC(32'h0), .FENCE_DRAIN(2), .ALIGN_BITS(2)
    ) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (q_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] obs(int sel);
        case (sel)
            0:       return p_if.pc_out;
            1:       return p_if.predecessor;
            2:       return p_if.successor;
            3:       return {31'd0, p_if.fence_busy};
            4:       return {31'd0, p_if.misaligned};
            5:       return q_if.pc_out;
            6:       return {31'd0, q_if.misaligned};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic push(string tag, int sel, logic [31:0] e);
        sb_item_t it;
        it.tag = tag;
        it.sel = sel;
        it.exp = e;
        sb.push_back(it);
    endtask

    task automatic step();
        sb_item_t it;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            chk(it.tag, obs(it.sel), it.exp);
        end
    endtask

    task automatic clear_ctl();
        p_if.stall = 0; p_if.branch = 0; p_if.jump = 0; p_if.jalr_sel = 0;
        p_if.funct3 = 3'b000; p_if.zero = 0; p_if.less_than = 0; p_if.less_than_u = 0;
        p_if.imm = 0; p_if.alu_out = 0; p_if.fence = 0; p_if.mem_idle = 1;
        p_if.trap = 0; p_if.trap_vec = 0;
        q_if.stall = 0; q_if.branch = 0; q_if.jump = 0; q_if.jalr_sel = 0;
        q_if.funct3 = 3'b000; q_if.zero = 0; q_if.less_than = 0; q_if.less_than_u = 0;
        q_if.imm = 0; q_if.alu_out = 0; q_if.fence = 0; q_if.mem_idle = 1;
        q_if.trap = 0; q_if.trap_vec = 0;
    endtask

    task automatic trap_p(logic [31:0] vec);
        p_if.trap = 1; p_if.trap_vec = vec;
        push("trap_set_p", 0, vec);
        step();
        p_if.trap = 0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        clear_ctl();

        // Reset state
        step();
        push("rst_pc", 0, 32'h0);
        push("rst_pred", 1, 32'h0);
        push("rst_succ", 2, 32'h0);
        push("rst_busy", 3, 32'h0);
        push("rst_mis", 4, 32'h0);
        step();
        reset = 1'b1;

        // Sequential 1..7, then mid-run reset
        for (int i = 1; i <= 7; i++) begin
            push($sformatf("seq_%0d", i), 0, 32'(i));
            step();
        end
        reset = 1'b0;
        push("mid_reset", 0, 32'h0);
        step();
        reset = 1'b1;

        // Branch set from pc=0x10
        trap_p(32'h10);
        p_if.branch = 1; p_if.imm = 32'hFFFF_FFFC; p_if.funct3 = 3'b101; p_if.less_than = 0;
        #1 chk("bge_redirect", {31'd0, p_if.redirect}, 32'h1);
        push("bge_pc", 0, 32'h0C);
        step();
        p_if.branch = 0;
        trap_p(32'h10);
        p_if.branch = 1; p_if.funct3 = 3'b110; p_if.less_than_u = 0;
        #1 chk("bltu_redirect", {31'd0, p_if.redirect}, 32'h0);
        push("bltu_pc", 0, 32'h11);
        step();
        p_if.branch = 0;
        trap_p(32'h10);
        p_if.branch = 1; p_if.funct3 = 3'b010; p_if.zero = 1; p_if.less_than = 1;
        push("f010_pc", 0, 32'h11);
        step();
        clear_ctl();

        // JALR alignment on the aligned instance
        q_if.trap = 1; q_if.trap_vec = 32'h100;
        push("q_trap", 5, 32'h100);
        step();
        q_if.trap = 0;
        q_if.jump = 1; q_if.jalr_sel = 1; q_if.alu_out = 32'h202;
        #1 chk("jalr_bad_redirect", {31'd0, q_if.redirect}, 32'h0);
        push("jalr_bad_pc", 5, 32'h104);
        push("jalr_bad_mis", 6, 32'h1);
        step();
        q_if.jump = 0; q_if.jalr_sel = 0;
        push("mis_drop_pc", 5, 32'h108);
        push("mis_drop", 6, 32'h0);
        step();
        q_if.jump = 1; q_if.jalr_sel = 1; q_if.alu_out = 32'h200;
        #1 chk("jalr_ok_redirect", {31'd0, q_if.redirect}, 32'h1);
        push("jalr_ok_pc", 5, 32'h200);
        push("jalr_ok_mis", 6, 32'h0);
        step();
        clear_ctl();

        // Fence with memory idle: busy for exactly 3 cycles
        trap_p(32'h20);
        p_if.fence = 1; p_if.mem_idle = 1; p_if.branch = 1; p_if.zero = 1; p_if.imm = 32'h40;
        #1 chk("fence_vs_branch_redirect", {31'd0, p_if.redirect}, 32'h0);
        push("fence_pred", 1, 32'h20);
        push("fence_succ", 2, 32'h21);
        push("fence_busy1", 3, 32'h1);
        push("fence_hold1", 0, 32'h20);
        step();
        p_if.fence = 0; p_if.branch = 0;
        push("fence_busy2", 3, 32'h1);
        push("fence_hold2", 0, 32'h20);
        step();
        push("fence_busy3", 3, 32'h1);
        push("fence_hold3", 0, 32'h20);
        step();
        push("fence_done_busy", 3, 32'h0);
        push("fence_done_pc", 0, 32'h21);
        step();

        // Fence with memory busy for 5 cycles
        p_if.fence = 1; p_if.mem_idle = 0;
        push("fence2_pred", 1, 32'h21);
        push("fence2_succ", 2, 32'h22);
        step();
        p_if.fence = 0;
        for (int i = 0; i < 5; i++) begin
            push($sformatf("drain_hold_pc_%0d", i), 0, 32'h21);
            push($sformatf("drain_hold_busy_%0d", i), 3, 32'h1);
            step();
        end
        p_if.mem_idle = 1;
        push("resume_busy", 3, 32'h1);
        push("resume_pc", 0, 32'h21);
        step();
        push("fence2_done_pc", 0, 32'h22);
        push("fence2_done_busy", 3, 32'h0);
        step();

        // Trap during DRAIN
        p_if.fence = 1;
        push("fence3_busy", 3, 32'h1);
        step();
        p_if.fence = 0;
        p_if.trap = 1; p_if.trap_vec = 32'h80;
        push("trap_mid_pc", 0, 32'h80);
        push("trap_mid_pred", 1, 32'h22);
        push("trap_mid_succ", 2, 32'h23);
        push("trap_mid_busy", 3, 32'h0);
        step();
        p_if.trap = 0;
        push("after_trap_pc", 0, 32'h81);
        push("after_trap_busy", 3, 32'h0);
        step();

        // Wrap and stall
        trap_p(32'hFFFF_FFFF);
        #1 chk("wrap_next_pc", p_if.next_pc, 32'h0);
        push("wrap_pc", 0, 32'h0);
        step();
        p_if.stall = 1; p_if.branch = 1; p_if.funct3 = 3'b000; p_if.zero = 1; p_if.imm = 32'h40;
        #1 chk("stall_redirect", {31'd0, p_if.redirect}, 32'h0);
        push("stall_pc", 0, 32'h0);
        step();
        p_if.stall = 0;
        #1 chk("unstall_redirect", {31'd0, p_if.redirect}, 32'h1);
        push("unstall_pc", 0, 32'h40);
        step();
        clear_ctl();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation program-counter unit for the RV32 core.
- Owns the PC register and resolves the full B-type condition set, JAL/JALR and trap redirect.
- Runs a fence drain state machine that freezes fetch, captures predecessor/successor PCs and resumes when memory is idle.
- Sits between decode/ALU and the instruction fetch port.

Parameters:
- XLEN, 32, datapath/PC width.
- PC_STEP, 1, sequential increment (1 = word-addressed imem, 4 = byte-addressed).
- RESET_PC, 0, PC value loaded on reset.
- FENCE_DRAIN, 2, minimum cycles the PC is held in DRAIN. Legal range is 1..15.
- ALIGN_BITS, 0, number of low target bits that must be zero. 0 disables the check.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-low.
- stall, input, 1, hold PC this cycle (pipeline hazard).
- branch, input, 1, current instruction is B-type.
- jump, input, 1, current instruction is JAL/JALR.
- jalr_sel, input, 1, jump target taken from alu_out (JALR) rather than pc+imm.
- funct3, input, 3, branch condition code.
- zero, input, 1, ALU result equal.
- less_than, input, 1, ALU signed less-than.
- less_than_u, input, 1, ALU unsigned less-than.
- imm, input, XLEN, sign-extended branch/JAL offset, in PC units.
- alu_out, input, XLEN, JALR target.
- fence, input, 1, current instruction is FENCE.
- mem_idle, input, 1, data memory has no outstanding accesses.
- trap, input, 1, redirect to trap_vec (highest priority after reset).
- trap_vec, input, XLEN, trap target.
- pc_out, output, XLEN, registered current PC.
- next_pc, output, XLEN, combinational pc_out + PC_STEP.
- predecessor, output, XLEN, PC of the most recent fence.
- successor, output, XLEN, PC following the most recent fence.
- fence_busy, output, 1, high in DRAIN and RESUME.
- redirect, output, 1, combinational: taken branch/jump is being applied this cycle.
- misaligned, output, 1, registered one-cycle pulse on a rejected target.

Behaviour:
- Reset (reset==0 at a clock edge):
  - pc_out=RESET_PC; predecessor=0; successor=0.
  - fence_busy=0; misaligned=0; FSM=IDLE. Reset aborts any in-progress fence.
- All arithmetic is modulo 2^XLEN. next_pc wraps; the pc+imm target wraps.
- Condition by funct3:
  - 000 zero; 001 ~zero.
  - 100 less_than; 101 ~less_than.
  - 110 less_than_u; 111 ~less_than_u.
  - 010/011 never taken.
- taken = jump | (branch & cond).
- Target = (jump & jalr_sel) ? alu_out : pc_out+imm.
- bad = taken & ALIGN_BITS>0 & target[ALIGN_BITS-1:0]!=0.
- Update priority at each edge (reset high): trap > FSM non-IDLE > stall > fence start > taken > sequential.
  - trap: pc<=trap_vec. If in DRAIN/RESUME, the fence is aborted (FSM->IDLE, fence_busy drops next cycle). predecessor/successor keep captured values.
  - stall in IDLE: pc and FSM hold; fence/branch inputs are ignored.
  - taken & ~bad: pc<=target; redirect=1 that cycle.
  - taken & bad: pc<=next_pc (treated as not taken); misaligned=1 for exactly the following cycle; redirect=0.
  - otherwise: pc<=next_pc.
- Fence FSM (stall is ignored in DRAIN/RESUME):
  - IDLE->DRAIN on fence & ~stall & ~trap. Capture predecessor<=pc_out, successor<=next_pc, cnt<=FENCE_DRAIN-1. PC held. fence & branch together: fence wins.
  - DRAIN: PC held; cnt decrements to 0 and saturates there. Exit to RESUME only when cnt==0 & mem_idle. If mem_idle stays low, DRAIN holds indefinitely.
  - RESUME: pc<=successor; next state IDLE.
  - Minimum fence cost is FENCE_DRAIN+1 cycles, during which pc_out is held.
- fence_busy is registered: high exactly while state is DRAIN or RESUME.
- redirect is 0 whenever state != IDLE, stall=1 or trap=1.

Test Plan:
- Reset/sequential: release reset with defaults, no controls -> pc_out 0,1,2,3 on successive edges. Drive reset low mid-run at pc=7 -> pc_out=0 next edge.
- Branch set: pc=0x10, imm=0xFFFFFFFC.
  - funct3=101, less_than=0 -> pc=0x0C, redirect=1.
  - funct3=110, less_than_u=0 -> pc=0x11.
  - funct3=010 -> pc=0x11.
- JALR/alignment: ALIGN_BITS=2, PC_STEP=4, pc=0x100, jump=1, jalr_sel=1.
  - alu_out=0x202 -> pc=0x104, misaligned high exactly one cycle.
  - alu_out=0x200 -> pc=0x200.
- Fence: pc=0x20, fence=1, mem_idle=1 -> predecessor=0x20, successor=0x21, fence_busy high 3 cycles, pc held at 0x20, then pc=0x21. Repeat with mem_idle low 5 cycles -> hold extends until mem_idle rises.
- Trap mid-fence: during DRAIN, trap=1, trap_vec=0x80 -> pc=0x80 next edge, fence_busy low the following cycle, predecessor/successor unchanged.
- Wrap/stall: pc=0xFFFFFFFF -> next pc=0. stall=1 together with taken branch -> pc holds, redirect=0.
